// File: rtl/rat_flow_ctrl.sv
// Program-flow controller for the pipelined RAT MCU: resolves branches and returns,
// sequences interrupt entry, squashes wrong-path fetches and keeps a C/Z shadow stack.
module rat_flow_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned SHADOW_DEPTH = 4,
    localparam int unsigned LVL_W = $clog2(SHADOW_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FC_DEC_VALID,
    input  logic             FC_COND_BRN,
    input  logic [1:0]       FC_COND_BRN_TYPE,
    input  logic             FC_UNCOND_BRN,
    input  logic             FC_RET,
    input  logic             FC_RETI,
    input  logic             FC_RETI_IE,
    input  logic             FC_C,
    input  logic             FC_Z,
    input  logic             FC_INT,
    input  logic             FC_I_EN,
    input  logic             FC_STALL,
    output logic             FC_PC_LD,
    output logic [1:0]       FC_PC_MUX_SEL,
    output logic             FC_FLUSH,
    output logic             FC_INT_ACK,
    output logic             FC_I_SET,
    output logic             FC_I_CLR,
    output logic             FC_FLG_RESTORE,
    output logic             FC_SHAD_C,
    output logic             FC_SHAD_Z,
    output logic [LVL_W-1:0] FC_NEST_LVL,
    output logic             FC_SHAD_OVF,
    output logic             FC_SHAD_UNF
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = (SHADOW_DEPTH > 1) ? $clog2(SHADOW_DEPTH) : 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [LVL_W-1:0]   lvl_q, lvl_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [1:0]         stk_q [SHADOW_DEPTH];
    logic               push_en;
    logic               redirect;
    logic               cond_taken;

    always_comb begin
        case (FC_COND_BRN_TYPE)
            2'b00:   cond_taken = ~FC_C;
            2'b01:   cond_taken = FC_C;
            2'b10:   cond_taken = FC_Z;
            default: cond_taken = ~FC_Z;
        endcase
    end

    // Next state and Mealy redirect outputs; everything is forced low while RST is high.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        lvl_d          = lvl_q;
        ovf_d          = ovf_q;
        unf_d          = unf_q;
        push_en        = 1'b0;
        redirect       = 1'b0;
        FC_PC_LD       = 1'b0;
        FC_PC_MUX_SEL  = 2'b00;
        FC_FLUSH       = 1'b0;
        FC_INT_ACK     = 1'b0;
        FC_I_SET       = 1'b0;
        FC_I_CLR       = 1'b0;
        FC_FLG_RESTORE = 1'b0;
        FC_SHAD_C      = 1'b0;
        FC_SHAD_Z      = 1'b0;
        FC_NEST_LVL    = '0;
        FC_SHAD_OVF    = 1'b0;
        FC_SHAD_UNF    = 1'b0;
        if (!RST) begin
            FC_NEST_LVL = lvl_q;
            FC_SHAD_OVF = ovf_q;
            FC_SHAD_UNF = unf_q;
            case (state_q)
                RUN: begin
                    if (!FC_STALL) begin
                        if (FC_INT && FC_I_EN) begin
                            redirect      = 1'b1;
                            FC_PC_LD      = 1'b1;
                            FC_PC_MUX_SEL = 2'b10;
                            FC_I_CLR      = 1'b1;
                            FC_INT_ACK    = 1'b1;
                            if (lvl_q == LVL_W'(SHADOW_DEPTH)) begin
                                ovf_d = 1'b1;
                            end else begin
                                push_en = 1'b1;
                                lvl_d   = lvl_q + LVL_W'(1);
                            end
                        end else if (FC_DEC_VALID) begin
                            if (FC_RETI) begin
                                redirect       = 1'b1;
                                FC_PC_LD       = 1'b1;
                                FC_PC_MUX_SEL  = 2'b01;
                                FC_FLG_RESTORE = 1'b1;
                                FC_I_SET       = FC_RETI_IE;
                                FC_I_CLR       = ~FC_RETI_IE;
                                if (lvl_q == '0) begin
                                    unf_d = 1'b1;
                                end else begin
                                    lvl_d = lvl_q - LVL_W'(1);
                                    {FC_SHAD_C, FC_SHAD_Z} = stk_q[IDX_W'(lvl_q - LVL_W'(1))];
                                end
                            end else if (FC_RET) begin
                                redirect      = 1'b1;
                                FC_PC_LD      = 1'b1;
                                FC_PC_MUX_SEL = 2'b01;
                            end else if (FC_UNCOND_BRN || (FC_COND_BRN && cond_taken)) begin
                                redirect      = 1'b1;
                                FC_PC_LD      = 1'b1;
                                FC_PC_MUX_SEL = 2'b00;
                            end
                        end
                        if (redirect && (FLUSH_CYCLES != 0)) begin
                            state_d = FLUSH;
                            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                        end
                    end
                end
                default: begin
                    FC_FLUSH = 1'b1;
                    if (!FC_STALL) begin
                        if (cnt_q == '0) begin
                            state_d = RUN;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RUN;
            cnt_q   <= '0;
            lvl_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < int'(SHADOW_DEPTH); i++) begin
                stk_q[i] <= 2'b00;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (push_en) begin
                stk_q[IDX_W'(lvl_q)] <= {FC_C, FC_Z};
            end
        end
    end

endmodule

// File: tb/tb_rat_flow_ctrl.sv
// Directed scoreboard bench for rat_flow_ctrl: instance A (2 flush cycles, depth 2)
// and instance B (3 flush cycles, depth 4) share one stimulus stream.
module tb_rat_flow_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RST, dv, cb, ub, rt, ri, rie, c, z, it, ien, st;
    logic [1:0] ct;

    logic       a_pl, a_fl, a_ak, a_is, a_ic, a_rs, a_sc, a_sz, a_ov, a_un;
    logic [1:0] a_mx, a_lv;
    logic       b_pl, b_fl, b_ak, b_is, b_ic, b_rs, b_sc, b_sz, b_ov, b_un;
    logic [1:0] b_mx;
    logic [2:0] b_lv;

    rat_flow_ctrl #(.FLUSH_CYCLES(2), .SHADOW_DEPTH(2)) dut_a (
        .CLK(CLK), .RST(RST), .FC_DEC_VALID(dv), .FC_COND_BRN(cb), .FC_COND_BRN_TYPE(ct),
        .FC_UNCOND_BRN(ub), .FC_RET(rt), .FC_RETI(ri), .FC_RETI_IE(rie), .FC_C(c), .FC_Z(z),
        .FC_INT(it), .FC_I_EN(ien), .FC_STALL(st), .FC_PC_LD(a_pl), .FC_PC_MUX_SEL(a_mx),
        .FC_FLUSH(a_fl), .FC_INT_ACK(a_ak), .FC_I_SET(a_is), .FC_I_CLR(a_ic),
        .FC_FLG_RESTORE(a_rs), .FC_SHAD_C(a_sc), .FC_SHAD_Z(a_sz), .FC_NEST_LVL(a_lv),
        .FC_SHAD_OVF(a_ov), .FC_SHAD_UNF(a_un)
    );

    rat_flow_ctrl #(.FLUSH_CYCLES(3), .SHADOW_DEPTH(4)) dut_b (
        .CLK(CLK), .RST(RST), .FC_DEC_VALID(dv), .FC_COND_BRN(cb), .FC_COND_BRN_TYPE(ct),
        .FC_UNCOND_BRN(ub), .FC_RET(rt), .FC_RETI(ri), .FC_RETI_IE(rie), .FC_C(c), .FC_Z(z),
        .FC_INT(it), .FC_I_EN(ien), .FC_STALL(st), .FC_PC_LD(b_pl), .FC_PC_MUX_SEL(b_mx),
        .FC_FLUSH(b_fl), .FC_INT_ACK(b_ak), .FC_I_SET(b_is), .FC_I_CLR(b_ic),
        .FC_FLG_RESTORE(b_rs), .FC_SHAD_C(b_sc), .FC_SHAD_Z(b_sz), .FC_NEST_LVL(b_lv),
        .FC_SHAD_OVF(b_ov), .FC_SHAD_UNF(b_un)
    );

    typedef struct packed {
        logic       pc_ld;
        logic [1:0] mux;
        logic       flush, ack, iset, iclr, rest, shc, shz;
        logic [2:0] lvl;
        logic       ovf, unf;
    } exp_t;

    exp_t obs_a, obs_b;
    assign obs_a = {a_pl, a_mx, a_fl, a_ak, a_is, a_ic, a_rs, a_sc, a_sz, {1'b0, a_lv}, a_ov, a_un};
    assign obs_b = {b_pl, b_mx, b_fl, b_ak, b_is, b_ic, b_rs, b_sc, b_sz, b_lv, b_ov, b_un};

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic exp_t mk(input logic pl, input logic [1:0] mx, input logic fl, ak, is,
                                ic, rs, sc, sz, input logic [2:0] lv, input logic ov, un);
        return {pl, mx, fl, ak, is, ic, rs, sc, sz, lv, ov, un};
    endfunction

    task automatic drive(input logic r, d, cbi, input logic [1:0] cti, input logic u, rti, rii,
                         riei, ci, zi, iti, ieni, sti);
        RST = r; dv = d; cb = cbi; ct = cti; ub = u; rt = rti; ri = rii; rie = riei;
        c = ci; z = zi; it = iti; ien = ieni; st = sti;
    endtask

    task automatic idle(input logic r);
        drive(r, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Expected value enters the scoreboard when stimulus is applied, leaves it at the sample point.
    task automatic chk(input string tag, input bit use_b, input exp_t e);
        exp_t got, want;
        sb_q.push_back(e);
        @(negedge CLK);
        want = sb_q.pop_front();
        got  = use_b ? obs_b : obs_a;
        n_chk++;
        assert (got === want)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
        @(posedge CLK);
        #1;
    endtask

    localparam exp_t ZERO = '0;

    initial begin
        idle(1);
        chk("rst_a", 0, ZERO);

        drive(0, 1, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("brcc_taken", 0, mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(0, 1, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("flush1_brn_killed", 0, mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("flush2_brn_killed", 0, mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        idle(0);
        chk("flush_end", 0, ZERO);

        drive(0, 1, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("brcs_not_taken", 0, ZERO);
        drive(0, 1, 1, 2'b11, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("brne_not_taken", 0, ZERO);
        idle(0);
        chk("still_run", 0, ZERO);

        drive(0, 1, 0, 2'b00, 1, 0, 0, 0, 1, 0, 1, 1, 0);
        chk("int_over_brn", 0, mk(1, 2'b10, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        idle(0);
        chk("int_flush1", 0, mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        chk("int_flush2", 0, mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        drive(0, 1, 0, 2'b00, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        chk("retie", 0, mk(1, 2'b01, 0, 0, 1, 0, 1, 1, 0, 1, 0, 0));
        idle(0);
        chk("retie_flush1", 0, mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("retie_flush2", 0, mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 2'b00, 0, 0, 0, 0, logic'(k % 2), logic'(1 - k % 2), 1, 1, 0);
            chk($sformatf("nest_ack%0d", k), 0,
                mk(1, 2'b10, 0, 1, 0, 1, 0, 0, 0, 3'((k < 2) ? k : 2), logic'(k >= 3), 0));
            for (int j = 0; j < 2; j++) begin
                chk($sformatf("nest_flush%0d_%0d", k, j), 0,
                    mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 3'((k < 1) ? k + 1 : 2), logic'(k >= 2), 0));
            end
        end
        idle(0);
        chk("nest_sat", 0, mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0));

        drive(0, 1, 0, 2'b00, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        chk("retid_pop2", 0, mk(1, 2'b01, 0, 0, 0, 1, 1, 1, 0, 2, 1, 0));
        idle(0);
        chk("pop2_flush1", 0, mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        chk("pop2_flush2", 0, mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        drive(0, 1, 0, 2'b00, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        chk("retid_pop1", 0, mk(1, 2'b01, 0, 0, 0, 1, 1, 0, 1, 1, 1, 0));
        idle(0);
        chk("pop1_flush1", 0, mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        chk("pop1_flush2", 0, mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        drive(0, 1, 0, 2'b00, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        chk("retid_underflow", 0, mk(1, 2'b01, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        idle(0);
        chk("unf_flush1", 0, mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        chk("unf_flush2", 0, mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        chk("unf_sticky", 0, mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));

        idle(1);
        chk("rst_b", 1, ZERO);
        idle(0);
        chk("sticky_clr", 0, ZERO);

        drive(0, 1, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("stall_run", 1, ZERO);
        drive(0, 1, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("b_brn", 1, mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int j = 0; j < 5; j++) begin
            idle(0);
            st = (j == 1 || j == 2);
            chk($sformatf("stall_flush%0d", j), 1, mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        idle(0);
        chk("stall_flush_end", 1, ZERO);

        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 1, 1, 1, 0);
        chk("b_int", 1, mk(1, 2'b10, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        idle(0);
        chk("b_int_flush1", 1, mk(0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        idle(1);
        chk("rst_mid_flush", 1, ZERO);
        idle(0);
        chk("post_rst_run", 1, ZERO);
        chk("post_rst_idle", 1, ZERO);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
